// File: rtl/shared_adder_sched.sv
// shared_adder_sched: time-shares one external slow ripple adder between two
// requesters (0 = ALU path, 1 = branch/address path). A winner's operands are
// registered onto the adder, the result is captured after SETTLE cycles and
// returned with a valid/ready response tagged with the owner ID.
// Optional feature: define SHARED_ADDER_RR_EN for round-robin arbitration;
// otherwise requester 0 has fixed priority.
module shared_adder_sched #(
   parameter int N      = 64,
   parameter int SETTLE = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   req_valid,
   output logic [1:0]   req_ready,
   input  logic [N-1:0] req_a0,
   input  logic [N-1:0] req_b0,
   input  logic [N-1:0] req_a1,
   input  logic [N-1:0] req_b1,
   input  logic [1:0]   req_sub,
   output logic [N-1:0] adder_in1,
   output logic [N-1:0] adder_in2,
   output logic         adder_sub,
   input  logic [N-1:0] adder_out,
   input  logic         adder_of,
   input  logic         adder_co,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic         rsp_id,
   output logic [N-1:0] rsp_sum,
   output logic [3:0]   rsp_flags
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t       state, state_nxt;
   logic [7:0]   cnt;
   logic         owner;
   logic         ptr;
   logic         gnt;
   logic         gnt_vld;
   logic         accept;
   logic         capture;
   logic         rsp_hs;
   logic [N-1:0] a_sel;
   logic [N-1:0] b_sel;
   logic         sub_sel;

`ifdef SHARED_ADDER_RR_EN
   // Priority pointer hands preference to the non-owner after each response.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)       ptr <= 1'b0;
      else if (rsp_hs) ptr <= ~owner;
   end
`else
   // Fixed priority: requester 0 always preferred.
   assign ptr = 1'b0;
`endif

   // Grant: pointer's requester first, the other one if only it is asking.
   always_comb begin
      gnt     = ptr;
      gnt_vld = 1'b0;
      if (req_valid[ptr]) begin
         gnt     = ptr;
         gnt_vld = 1'b1;
      end else if (req_valid[~ptr]) begin
         gnt     = ~ptr;
         gnt_vld = 1'b1;
      end
   end

   assign a_sel   = gnt ? req_a1 : req_a0;
   assign b_sel   = gnt ? req_b1 : req_b0;
   assign sub_sel = req_sub[gnt];

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and handshake strobes.
   always_comb begin
      state_nxt = state;
      req_ready = 2'b00;
      accept    = 1'b0;
      capture   = 1'b0;
      rsp_hs    = 1'b0;
      case (state)
         IDLE: begin
            if (gnt_vld) begin
               req_ready[gnt] = 1'b1;
               accept         = 1'b1;
               state_nxt      = WAIT;
            end
         end
         WAIT: begin
            if (cnt == 8'd0) begin
               capture   = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rsp_valid = (state == DONE);

   // Operand launch and settle counter; operands only change on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         adder_in1 <= '0;
         adder_in2 <= '0;
         adder_sub <= 1'b0;
         owner     <= 1'b0;
         cnt       <= 8'd0;
      end else if (accept) begin
         adder_in1 <= a_sel;
         adder_in2 <= sub_sel ? ~b_sel : b_sel;
         adder_sub <= sub_sel;
         owner     <= gnt;
         cnt       <= 8'(SETTLE - 1);
      end else if (state == WAIT && !capture) begin
         cnt <= cnt - 8'd1;
      end
   end

   // Result capture with NZVC; held until the response handshake.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_sum   <= '0;
         rsp_flags <= 4'd0;
         rsp_id    <= 1'b0;
      end else if (capture) begin
         rsp_sum   <= adder_out;
         rsp_flags <= {adder_out[N-1], (adder_out == '0), adder_of, adder_co};
         rsp_id    <= owner;
      end
   end

endmodule

// File: tb/tb_shared_adder_sched.sv
// Directed bench for shared_adder_sched: vector table of single operations,
// plus hand sequences for backpressure, contention, SETTLE=1 and mid-WAIT
// reset. A behavioural adder model closes the loop on the adder ports.
module tb_shared_adder_sched;
   localparam int N  = 64;
   localparam int ST = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   req_valid;
   logic [N-1:0] req_a0, req_b0, req_a1, req_b1;
   logic [1:0]   req_sub;
   logic         rsp_ready;

   logic [1:0]   req_ready;
   logic [N-1:0] adder_in1, adder_in2, adder_out, rsp_sum;
   logic         adder_sub, adder_of, adder_co, rsp_valid, rsp_id;
   logic [3:0]   rsp_flags;

   logic [1:0]   s_ready;
   logic [N-1:0] s_in1, s_in2, s_out, s_sum;
   logic         s_sub, s_of, s_co, s_valid, s_id;
   logic [3:0]   s_flags;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shared_adder_sched #(.N(N), .SETTLE(ST)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_sub(req_sub), .adder_in1(adder_in1), .adder_in2(adder_in2),
      .adder_sub(adder_sub), .adder_out(adder_out), .adder_of(adder_of),
      .adder_co(adder_co), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_flags(rsp_flags));

   shared_adder_sched #(.N(N), .SETTLE(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
      .req_sub(req_sub), .adder_in1(s_in1), .adder_in2(s_in2),
      .adder_sub(s_sub), .adder_out(s_out), .adder_of(s_of),
      .adder_co(s_co), .rsp_valid(s_valid), .rsp_ready(rsp_ready),
      .rsp_id(s_id), .rsp_sum(s_sum), .rsp_flags(s_flags));

   // Ripple adder model: in1 + in2 + cin, with carry-out and signed overflow.
   function automatic logic [N+1:0] add_model(input logic [N-1:0] x, y, input logic cin);
      logic [N:0] s;
      logic       v;
      s = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
      v = (x[N-1] == y[N-1]) && (s[N-1] != x[N-1]);
      return {v, s[N], s[N-1:0]};
   endfunction

   always_comb {adder_of, adder_co, adder_out} = add_model(adder_in1, adder_in2, adder_sub);
   always_comb {s_of, s_co, s_out}             = add_model(s_in1, s_in2, s_sub);

   task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic         id;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic         sub;
      logic [N-1:0] sum;
      logic [3:0]   flags;
   } vec_t;

   vec_t vt[7];

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One operation; hold > 0 applies response backpressure with both requesters asking.
   task automatic do_op(input vec_t v, input int hold);
      int   k;
      logic stable;
      logic [1:0] exp_rdy;
      @(negedge clk);
      req_sub = 2'b00;
      req_sub[v.id] = v.sub;
      if (v.id) begin req_a1 = v.a; req_b1 = v.b; req_valid = 2'b10; end
      else      begin req_a0 = v.a; req_b0 = v.b; req_valid = 2'b01; end
      #1;
      chk("req_ready_grant", N'(req_ready), v.id ? 64'd2 : 64'd1);
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      req_a0 = ~req_a0; req_b0 = ~req_b0; req_a1 = ~req_a1; req_b1 = ~req_b1;
      req_sub = ~req_sub;
      chk("adder_in1", adder_in1, v.a);
      chk("adder_in2", adder_in2, v.sub ? ~v.b : v.b);
      chk("adder_sub", N'(adder_sub), N'(v.sub));
      k = 0;
      @(negedge clk);
      while (!rsp_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk("latency", N'(k), N'(ST));
      chk("rsp_sum", rsp_sum, v.sum);
      chk("rsp_flags", N'(rsp_flags), N'(v.flags));
      chk("rsp_id", N'(rsp_id), N'(v.id));
      if (hold > 0) begin
         req_valid = 2'b11;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_sum !== v.sum || req_ready !== 2'b00) stable = 1'b0;
         end
         chk("backpressure_stable", N'(stable), 64'd1);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rsp_valid_after_hs", N'(rsp_valid), 64'd0);
      if (hold > 0) begin
`ifdef SHARED_ADDER_RR_EN
         exp_rdy = v.id ? 2'b01 : 2'b10;
`else
         exp_rdy = 2'b01;
`endif
         chk("idle_after_release", N'(req_ready), N'(exp_rdy));
         req_valid = 2'b00;
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   acc_q[$];
      logic rid_q[$];
      logic [N-1:0] rsum_q[$];
      logic seen;
      logic exp_id;
      vec_t bp;

      vt[0] = '{1'b0, 64'd256, 64'd100, 1'b0, 64'd356, 4'b0000};
      vt[1] = '{1'b1, 64'd20, 64'd5, 1'b1, 64'd15, 4'b0001};
      vt[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
      vt[3] = '{1'b1, 64'd5, 64'd5, 1'b1, 64'd0, 4'b0101};
      vt[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 4'b0101};
      vt[5] = '{1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1010};
      vt[6] = '{1'b0, 64'd3, 64'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
      bp    = '{1'b1, 64'd1000, 64'd24, 1'b0, 64'd1024, 4'b0000};

      reset = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0; req_sub = 2'b00;
      req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
      #1;
      chk("reset_rsp_valid", N'(rsp_valid), 64'd0);
      chk("reset_in1", adder_in1, 64'd0);
      chk("reset_in2", adder_in2, 64'd0);
      chk("reset_misc", N'({adder_sub, rsp_id, rsp_flags, req_ready}), 64'd0);
      chk("reset_sum", rsp_sum, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      req_valid = 2'b01;
      #1;
      chk("ready_after_reset", N'(req_ready), 64'd1);
      req_valid = 2'b00;

      foreach (vt[i]) do_op(vt[i], 0);
      do_op(bp, 20);

      // Contention: both requesters always valid, consumer always ready.
      do_reset();
      @(negedge clk);
      req_a0 = 64'd1; req_b0 = 64'd1; req_a1 = 64'd2; req_b1 = 64'd2;
      req_sub = 2'b00; req_valid = 2'b11; rsp_ready = 1'b1;
      for (int c = 0; c < 60; c++) begin
         #1;
         if (req_ready != 2'b00) acc_q.push_back(c);
         if (rsp_valid) begin
            rid_q.push_back(rsp_id);
            rsum_q.push_back(rsp_sum);
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      chk("contention_rsp_count", N'(rid_q.size() >= 4), 64'd1);
      chk("contention_acc_count", N'(acc_q.size() >= 4), 64'd1);
      for (int i = 0; i < 4 && i < rid_q.size(); i++) begin
`ifdef SHARED_ADDER_RR_EN
         exp_id = i[0];
`else
         exp_id = 1'b0;
`endif
         chk("contention_id", N'(rid_q[i]), N'(exp_id));
         chk("contention_sum", rsum_q[i], exp_id ? 64'd4 : 64'd2);
      end
      for (int i = 0; i < 3 && i + 1 < acc_q.size(); i++)
         chk("contention_spacing", N'(acc_q[i+1] - acc_q[i]), N'(ST + 2));

      // SETTLE = 1: result one edge after accept.
      do_reset();
      @(negedge clk);
      req_a0 = 64'd7; req_b0 = 64'd8; req_sub = 2'b00; req_valid = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("settle1_not_yet", N'(s_valid), 64'd0);
      @(negedge clk);
      chk("settle1_valid", N'(s_valid), 64'd1);
      chk("settle1_sum", s_sum, 64'd15);

      // Reset mid-WAIT with counter at 3.
      do_reset();
      @(negedge clk);
      req_a0 = 64'd111; req_b0 = 64'd222; req_sub = 2'b01; req_valid = 2'b01;
      @(posedge clk);
      #1;
      req_valid = 2'b00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midwait_in1", adder_in1, 64'd0);
      chk("midwait_in2", adder_in2, 64'd0);
      chk("midwait_misc", N'({rsp_valid, adder_sub, rsp_id, rsp_flags}), 64'd0);
      chk("midwait_sum", rsp_sum, 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("midwait_no_rsp", N'(seen), 64'd0);
      do_op(vt[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/shared_adder_sched.md
# shared_adder_sched

Multi-cycle scheduler that shares one `adder64_bit` ripple adder between two requesters (execute-stage ALU path and branch/address path). It arbitrates between them, registers the chosen operands onto the adder inputs, and waits a fixed settle time for the slow ripple/buffer path to resolve. It then captures the sum and NZVC flags and returns them with a valid/ready response handshake tagged with the requester ID.

## Interface
Parameters:
- `N`, 64: datapath width; must match the adder instance.
- `SETTLE`, 8: clock cycles from operand launch to result capture; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input 2: per-requester operation request.
- `req_ready` output 2: per-requester accept; at most one bit high.
- `req_a0`, `req_b0` input N each: requester 0 operands.
- `req_a1`, `req_b1` input N each: requester 1 operands.
- `req_sub` input 2: per-requester subtract select (1 = a − b).
- `adder_in1`, `adder_in2` output N each: registered drive to adder `input1`/`input2`.
- `adder_sub` output 1: registered drive to adder `sub_control`.
- `adder_out` input N: adder sum.
- `adder_of`, `adder_co` input 1 each: adder overflow and carry-out.
- `rsp_valid` output 1: result held and valid.
- `rsp_ready` input 1: consumer accepts result.
- `rsp_id` output 1: requester that owns the result.
- `rsp_sum` output N: captured sum.
- `rsp_flags` output 4: {N, Z, V, C}.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE:
  - Grant chosen combinationally from `req_valid` and the priority pointer.
  - `req_ready[g]` = 1 for the granted requester only; 0 in all other states.
  - Accept = `req_valid[g] & req_ready[g]`. On accept:
    - `adder_in1` ← a_g.
    - `adder_in2` ← `req_sub[g]` ? ~b_g : b_g.
    - `adder_sub` ← `req_sub[g]`.
    - Owner ← g; counter ← SETTLE−1; go to WAIT.
- WAIT:
  - Counter decrements each cycle; operand registers are held stable.
  - At counter = 0: capture `rsp_sum` ← `adder_out`, N = `adder_out[N-1]`, Z = (`adder_out` == 0), V = `adder_of`, C = `adder_co`, `rsp_id` ← owner.
  - Go to DONE.
- DONE:
  - `rsp_valid` = 1; all response outputs held stable.
  - On `rsp_valid & rsp_ready`: go to IDLE and update the priority pointer to !owner.
- Requests are never accepted while an operation is in flight or a response is pending.
- Requester inputs are sampled only on the accept edge; they may change afterwards.
- Subtraction convention: C = 1 means no borrow (two's-complement carry).

## Timing
- Reset (asynchronous):
  - State → IDLE; pointer → 0.
  - `adder_in1`, `adder_in2`, `adder_sub`, `rsp_sum`, `rsp_flags`, `rsp_id`, `rsp_valid` → 0.
  - `req_ready` follows IDLE grant rules immediately after reset deasserts.
- Latency: accept at edge T → `rsp_valid` high after edge T+SETTLE.
- Throughput with `rsp_ready` held high: one operation per SETTLE+2 cycles.
- SETTLE = 1: WAIT lasts exactly one cycle.
- Reset mid-WAIT or mid-DONE: the in-flight operation is discarded with no response.
- `req_valid` dropping after accept has no effect.
- Both `req_valid` bits high in IDLE: the pointer's requester wins.
- Response backpressure (`rsp_ready` = 0): DONE is held indefinitely with outputs stable.

## Configuration
- `SHARED_ADDER_RR_EN` defined: round-robin arbitration. The pointer flips to the non-owner after each response handshake.
- Not defined: fixed priority. Requester 0 always wins when both are valid; the pointer logic is compiled out.

## Test plan
- Add: requester 0 only, a=256, b=100, sub=0 → after SETTLE cycles, `rsp_sum`=356, flags=0000, `rsp_id`=0.
- Subtract: requester 1, a=20, b=5, sub=1 → `adder_in2`=~5, `adder_sub`=1, `rsp_sum`=15, flags=0001, `rsp_id`=1.
- Boundary flags:
  - 0x8000_0000_0000_0000 − 1 → sum 0x7FFF_FFFF_FFFF_FFFF, flags=0011.
  - 5 − 5 → sum 0, flags=0101.
- Contention: both requesters valid continuously, SETTLE=8, `rsp_ready`=1.
  - With RR: response IDs alternate 0,1,0,1; accepts 10 cycles apart.
  - Without RR: IDs are all 0.
- Backpressure: hold `rsp_ready`=0 for 20 cycles in DONE → `rsp_valid` and `rsp_sum` stable, `req_ready`=00 throughout; release → IDLE the next cycle.
- Reset mid-WAIT (counter=3): all outputs 0 asynchronously; no response emitted; a new request after reset completes normally with the correct sum.
